// File: rtl/button_command_encoder_if.sv
// Button inputs and command outputs shared between the encoder and its driver.
// The master side presses the buttons and watches the command code; the slave is the encoder.
interface button_command_encoder_if;
    logic       btn_inc;
    logic       btn_inc2;
    logic       btn_dec;
    logic       w1;
    logic       w0;
    logic       cmd_strobe;
    logic [1:0] fsm_state;

    modport master (
        output btn_inc, btn_inc2, btn_dec,
        input  w1, w0, cmd_strobe, fsm_state
    );

    modport slave (
        input  btn_inc, btn_inc2, btn_dec,
        output w1, w0, cmd_strobe, fsm_state
    );
endinterface

// File: rtl/button_command_encoder.sv
// Turns three bouncy push buttons into single-cycle up/down command codes
// (00 hold, 01 +1, 10 +2, 11 -1), with hold-to-auto-repeat.
module button_command_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    button_command_encoder_if.slave  bus
);
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RPT_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int TMR_W  = (HLD_W > RPT_W) ? HLD_W : RPT_W;

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_MAX = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] RPT_MAX  = TMR_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } state_e;

    // Bit order everywhere: [0] = inc, [1] = inc2, [2] = dec.
    logic [2:0]      raw;
    logic [2:0]      ff1_q, ff2_q;
    logic [2:0]      deb_q, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [2:0]      rise;
    logic [1:0]      pick_code;
    logic            latched_deb;

    state_e          state_q;
    logic [TMR_W-1:0] timer_q;
    logic [1:0]      latched_q;
    logic [1:0]      cmd_q;
    logic            strobe_q;

    assign raw = {bus.btn_dec, bus.btn_inc2, bus.btn_inc};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ff1_q      <= '0;
            ff2_q      <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            ff1_q      <= raw;
            ff2_q      <= ff1_q;
            deb_prev_q <= deb_q;
            // A level change must persist DEBOUNCE_CYCLES edges; any agreement restarts the count.
            for (int i = 0; i < 3; i++) begin
                if (ff2_q[i] != deb_q[i]) begin
                    if (db_cnt_q[i] == DB_MAX) begin
                        deb_q[i]    <= ff2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        pick_code = 2'b00;
        if (rise[2])      pick_code = 2'b11;
        else if (rise[1]) pick_code = 2'b10;
        else if (rise[0]) pick_code = 2'b01;
    end

    // The latched code doubles as the selector of the button being held.
    always_comb begin
        latched_deb = 1'b0;
        case (latched_q)
            2'b01:   latched_deb = deb_q[0];
            2'b10:   latched_deb = deb_q[1];
            2'b11:   latched_deb = deb_q[2];
            default: latched_deb = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            latched_q <= 2'b00;
            cmd_q     <= 2'b00;
            strobe_q  <= 1'b0;
        end else begin
            cmd_q    <= 2'b00;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_code != 2'b00) begin
                        latched_q <= pick_code;
                        cmd_q     <= pick_code;
                        strobe_q  <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!latched_deb) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else if (timer_q == HOLD_MAX) begin
                        cmd_q    <= latched_q;
                        strobe_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= REPEAT;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!latched_deb) begin
                        timer_q <= '0;
                        state_q <= IDLE;
                    end else if (timer_q == RPT_MAX) begin
                        cmd_q    <= latched_q;
                        strobe_q <= 1'b1;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.w1         = cmd_q[1];
    assign bus.w0         = cmd_q[0];
    assign bus.cmd_strobe = strobe_q;
    assign bus.fsm_state  = state_q;
endmodule
